// File: rtl/invaders_pkg.sv
// invaders_pkg: shared game constants and the alien-missile slot record.
// Contents: formation/missile geometry, LFSR seed, slot_t {active, x, y}.
package invaders_pkg;
  localparam int NUM_SLOTS = 3;
  localparam int NUM_COLS = 11;
  localparam int COL_PITCH = 16;
  localparam int STEP = 2;
  localparam int Y_FLOOR = 464;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef struct packed {
    logic active;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Ports: frame_clk (clock), Reset (async, active-high, loads SEED), o_state (current state).
module lfsr16 import invaders_pkg::*; #(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        frame_clk,
  input  logic        Reset,
  output logic [15:0] o_state
);
  logic [15:0] r_state;
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) r_state <= SEED;
    else r_state <= {r_state[14:0], r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10]};
  assign o_state = r_state;
endmodule

// File: rtl/alien_missile.sv
// alien_missile: launches, moves and retires up to NUM_SLOTS alien missiles.
// Ports: frame_clk, Reset (async, active-high); enable freezes motion/firing when low;
// column_alive, formation_X, formation_bottom_Y describe the formation; hit retires slots;
// missile_X/missile_Y/missile_on_screen are registered per-slot state; fire_event pulses on launch.
module alien_missile import invaders_pkg::*; #(
  parameter int          NUM_SLOTS    = invaders_pkg::NUM_SLOTS,
  parameter int          NUM_COLS     = invaders_pkg::NUM_COLS,
  parameter int          COL_PITCH    = invaders_pkg::COL_PITCH,
  parameter int          STEP         = invaders_pkg::STEP,
  parameter int          Y_FLOOR      = invaders_pkg::Y_FLOOR,
  parameter int          COOLDOWN_MIN = 20,
  parameter logic [15:0] LFSR_SEED    = invaders_pkg::LFSR_SEED
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic                       enable,
  input  logic [NUM_COLS-1:0]        column_alive,
  input  logic [9:0]                 formation_X,
  input  logic [9:0]                 formation_bottom_Y,
  input  logic [NUM_SLOTS-1:0]       hit,
  output logic [NUM_SLOTS-1:0][9:0]  missile_X,
  output logic [NUM_SLOTS-1:0][9:0]  missile_Y,
  output logic [NUM_SLOTS-1:0]       missile_on_screen,
  output logic                       fire_event
);
  logic [15:0] w_lfsr;
  logic [4:0]  w_start;
  logic [9:0]  w_col;
  logic        w_any_free;
  int          w_free_idx;
  int          w_idx;
  logic        w_fire;
  logic [9:0]  w_launch_x;
  slot_t       w_nxt [NUM_SLOTS];
  slot_t       r_slot [NUM_SLOTS];
  logic [7:0]  r_cooldown;
  logic        r_fire;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .o_state  (w_lfsr)
  );

  assign w_start = {1'b0, w_lfsr[3:0]} >= 5'(NUM_COLS) ? {1'b0, w_lfsr[3:0]} - 5'(NUM_COLS) : {1'b0, w_lfsr[3:0]};

  // Scan from the highest offset down so the smallest offset (first alive column) wins.
  always_comb begin
    w_col = '0;
    w_idx = 0;
    for (int k = NUM_COLS - 1; k >= 0; k--) begin
      w_idx = int'(w_start) + k;
      w_idx = w_idx >= NUM_COLS ? w_idx - NUM_COLS : w_idx;
      if (column_alive[w_idx]) w_col = 10'(w_idx);
    end
  end

  // Allocation looks only at registered state, so a slot retiring now is not reused until next cycle.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = 0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!r_slot[i].active) begin
        w_any_free = 1'b1;
        w_free_idx = i;
      end
  end

  assign w_fire = enable && r_cooldown == '0 && w_any_free && |column_alive;
  assign w_launch_x = formation_X + w_col * 10'(COL_PITCH) + 10'(COL_PITCH / 2 - 1);

  // Hit beats movement; the floor check is part of motion and so only happens while enabled.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_nxt[i] = r_slot[i];
      if (r_slot[i].active && (hit[i] || (enable && 11'(r_slot[i].y) + 11'(STEP) >= 11'(Y_FLOOR))))
        w_nxt[i] = '0;
      else if (r_slot[i].active && enable)
        w_nxt[i].y = r_slot[i].y + 10'(STEP);
      else if (w_fire && w_free_idx == i)
        w_nxt[i] = '{active: 1'b1, x: w_launch_x, y: formation_bottom_Y + 10'd8};
    end
  end

  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= '0;
      r_cooldown <= 8'(COOLDOWN_MIN);
      r_fire <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= w_nxt[i];
      r_cooldown <= w_fire ? 8'(COOLDOWN_MIN) + {3'b0, w_lfsr[4:0]} : (enable && r_cooldown != '0) ? r_cooldown - 8'd1 : r_cooldown;
      r_fire <= w_fire;
    end

  always_comb
    for (int i = 0; i < NUM_SLOTS; i++) begin
      missile_X[i] = r_slot[i].x;
      missile_Y[i] = r_slot[i].y;
      missile_on_screen[i] = r_slot[i].active;
    end
  assign fire_event = r_fire;
endmodule

// File: tb/tb_alien_missile.sv
// tb_alien_missile: self-checking bench for alien_missile against a behavioural game model.
module tb_alien_missile;
  localparam int NS = 3;
  localparam int NC = 11;

  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  logic enable = 1'b0;
  logic [NC-1:0] column_alive = '0;
  logic [9:0] formation_X = '0;
  logic [9:0] formation_bottom_Y = '0;
  logic [NS-1:0] hit = '0;
  logic [NS-1:0][9:0] missile_X;
  logic [NS-1:0][9:0] missile_Y;
  logic [NS-1:0] missile_on_screen;
  logic fire_event;

  int tests = 0;
  int fails = 0;

  int m_act [NS];
  int m_x [NS];
  int m_y [NS];
  int m_cd;
  int m_lfsr;
  bit m_fire;

  always #5 frame_clk = ~frame_clk;

  alien_missile dut (
    .frame_clk         (frame_clk),
    .Reset             (Reset),
    .enable            (enable),
    .column_alive      (column_alive),
    .formation_X       (formation_X),
    .formation_bottom_Y(formation_bottom_Y),
    .hit               (hit),
    .missile_X         (missile_X),
    .missile_Y         (missile_Y),
    .missile_on_screen (missile_on_screen),
    .fire_event        (fire_event)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0;
      m_x[i] = 0;
      m_y[i] = 0;
    end
    m_cd = 20;
    m_lfsr = 16'hACE1;
    m_fire = 0;
  endtask

  // One frame of the game rules, evaluated from the current inputs before the clock edge.
  task automatic model_step();
    bit fire;
    int fs, start, col, fb;
    fs = -1;
    for (int i = NS - 1; i >= 0; i--) if (m_act[i] == 0) fs = i;
    fire = enable && m_cd == 0 && fs >= 0 && column_alive != 0;
    start = m_lfsr & 15;
    if (start >= NC) start -= NC;
    col = -1;
    for (int k = 0; k < NC; k++) if (col < 0 && column_alive[(start + k) % NC]) col = (start + k) % NC;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] != 0 && (hit[i] || (enable && m_y[i] + 2 >= 464))) begin
        m_act[i] = 0;
        m_x[i] = 0;
        m_y[i] = 0;
      end else if (m_act[i] != 0 && enable) begin
        m_y[i] += 2;
      end else if (fire && i == fs) begin
        m_act[i] = 1;
        m_x[i] = formation_X + col * 16 + 7;
        m_y[i] = formation_bottom_Y + 8;
      end
    end
    m_cd = fire ? 20 + (m_lfsr & 31) : (enable && m_cd > 0) ? m_cd - 1 : m_cd;
    m_fire = fire;
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
  endtask

  task automatic cmp_model();
    logic [NS-1:0][9:0] ex, ey;
    logic [NS-1:0] eo;
    for (int i = 0; i < NS; i++) begin
      ex[i] = 10'(m_x[i]);
      ey[i] = 10'(m_y[i]);
      eo[i] = m_act[i] != 0;
    end
    tests++;
    if ({missile_on_screen, missile_X, missile_Y, fire_event} !== {eo, ex, ey, m_fire}) begin
      fails++;
      $display("FAIL model t=%0t on=%b/%b x=%h/%h y=%h/%h fire=%b/%b", $time,
               missile_on_screen, eo, missile_X, ex, missile_Y, ey, fire_event, m_fire);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
    cmp_model();
  endtask

  task automatic check_zero(input string name);
    check({name, "_on"}, int'(missile_on_screen), 0);
    check({name, "_xy"}, int'({missile_X, missile_Y} != '0), 0);
    check({name, "_fire"}, int'(fire_event), 0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    @(posedge frame_clk);
    #1;
    check_zero("reset");
    Reset = 1'b0;
  endtask

  task automatic wait_fire(input int bound, output int n);
    n = 0;
    while (!fire_event && n < bound) begin
      tick();
      n++;
    end
    if (!fire_event) check("fire_timeout", 0, 1);
  endtask

  typedef struct {
    logic [NC-1:0] alive;
    int fx;
    int fby;
    int ex;
  } vec_t;

  initial begin
    vec_t v [4];
    int n, y0, last_y;
    v[0] = '{11'b100_0000_0000, 100, 200, 267};
    v[1] = '{11'b000_0000_0001, 50, 100, 57};
    v[2] = '{11'b000_0010_0000, 0, 0, 87};
    v[3] = '{11'b100_0000_0000, 600, 300, 767};

    // First fire only after the full initial cooldown.
    do_reset();
    enable = 1'b1;
    column_alive = '1;
    formation_X = 10'd40;
    formation_bottom_Y = 10'd20;
    wait_fire(60, n);
    check("first_fire_cycle", n, 21);
    check("first_fire_slot0", int'(missile_on_screen), 1);

    // Single-alive-column launches land at a fixed X.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      enable = 1'b1;
      column_alive = v[t].alive;
      formation_X = 10'(v[t].fx);
      formation_bottom_Y = 10'(v[t].fby);
      wait_fire(60, n);
      check($sformatf("vec%0d_x", t), int'(missile_X[0]), v[t].ex);
      check($sformatf("vec%0d_y", t), int'(missile_Y[0]), v[t].fby + 8);
      if (t == 0) begin
        last_y = 0;
        n = 0;
        while (missile_on_screen[0] && n < 200) begin
          check("descent_y", int'(missile_Y[0]), 208 + 2 * n);
          last_y = missile_Y[0];
          tick();
          n++;
        end
        check("retire_last_y", last_y, 462);
        check("retire_xy", int'({missile_X[0], missile_Y[0]}), 0);
        check("retire_on", int'(missile_on_screen[0]), 0);
      end
    end

    // All slots busy: no launch; a hit frees a slot only from the next cycle.
    do_reset();
    enable = 1'b1;
    column_alive = '1;
    formation_X = 10'd10;
    formation_bottom_Y = 10'd0;
    n = 0;
    while (missile_on_screen != 3'b111 && n < 300) begin
      tick();
      n++;
    end
    check("full", int'(missile_on_screen), 7);
    n = 0;
    while (m_cd != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("full_no_fire", int'(fire_event), 0);
    check("full_still", int'(missile_on_screen), 7);
    hit = 3'b010;
    tick();
    hit = '0;
    check("hit1_cleared", int'(missile_on_screen[1]), 0);
    check("hit1_x", int'(missile_X[1]), 0);
    check("hit1_no_refill", int'(fire_event), 0);
    tick();
    check("hit1_others", int'({missile_on_screen[2], missile_on_screen[0]}), 3);

    // Disabled: positions frozen, but a hit still retires.
    enable = 1'b0;
    y0 = missile_Y[0];
    for (int k = 0; k < 5; k++) tick();
    check("frozen_y", int'(missile_Y[0]), y0);
    hit = 3'b001;
    tick();
    hit = '0;
    check("disabled_hit", int'(missile_on_screen[0]), 0);

    // Asynchronous reset mid-flight.
    check("pre_reset_active", int'(missile_on_screen != 0), 1);
    #2 Reset = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;

    // No alive columns: never fires.
    enable = 1'b1;
    column_alive = '0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      n += int'(fire_event);
    end
    check("dead_no_fire", n, 0);

    // Randomized play against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      enable = $urandom_range(0, 9) != 0;
      hit = $urandom_range(0, 7) == 0 ? 3'($urandom) : '0;
      if (k % 50 == 0) column_alive = $urandom_range(0, 4) == 0 ? '0 : 11'($urandom);
      formation_X = 10'($urandom_range(0, 800));
      formation_bottom_Y = 10'($urandom_range(0, 300));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
